// File: rtl/alu_arbiter_pkg.sv
// Shared types and defaults for the round-robin ALU arbiter.
// Holds the controller state encoding and the pointer wrap helper.
package alu_arbiter_pkg;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_R = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int wrap_inc(input int value, input int modulus);
        return (value + 1 >= modulus) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping from R-1 back to 0.
module rr_picker
    import alu_arbiter_pkg::*;
#(
    parameter int R = DEFAULT_R
) (
    input  logic [R-1:0]         req,
    input  logic [$clog2(R)-1:0] rr_ptr,
    output logic                 valid,
    output logic [$clog2(R)-1:0] index
);
    localparam int GW = $clog2(R);

    logic [GW:0] sum;

    // Scan from the farthest offset down so the closest hit to rr_ptr wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        sum   = '0;
        for (int k = R - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (GW + 1)'(k);
            if (sum >= (GW + 1)'(R)) begin
                sum = sum - (GW + 1)'(R);
            end
            if (req[sum[GW-1:0]]) begin
                valid = 1'b1;
                index = sum[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU among R requesters.
// Sequence per operation: IDLE (pick and latch) -> START -> WAIT -> DONE (ack).
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int R = DEFAULT_R
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [R-1:0]         req,
    input  logic [R*N-1:0]       req_A,
    input  logic [R*N-1:0]       req_B,
    output logic [R-1:0]         ack,
    output logic [N-1:0]         res_Y,
    output logic [N-1:0]         res_X,
    output logic [$clog2(R)-1:0] grant,
    output logic                 busy,
    output logic                 alu_start,
    input  logic                 alu_finished,
    output logic [N-1:0]         alu_A,
    output logic [N-1:0]         alu_B,
    input  logic [N-1:0]         alu_Y,
    input  logic [N-1:0]         alu_X
);
    localparam int GW = $clog2(R);

    state_t        state_reg, state_next;
    logic [GW-1:0] rr_ptr_reg;
    logic [GW-1:0] grant_reg;
    logic          just_acked_reg;
    logic [N-1:0]  alu_a_reg, alu_b_reg;
    logic [N-1:0]  res_y_reg, res_x_reg;

    logic [R-1:0]  req_eligible;
    logic [N-1:0]  a_slot [R];
    logic [N-1:0]  b_slot [R];
    logic          pick_valid;
    logic [GW-1:0] pick_index;

    // The requester acked last cycle sits out the very next IDLE evaluation.
    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_req
            assign a_slot[gi]       = req_A[gi*N +: N];
            assign b_slot[gi]       = req_B[gi*N +: N];
            assign req_eligible[gi] = req[gi] & ~(just_acked_reg & (grant_reg == GW'(gi)));
            assign ack[gi]          = (state_reg == DONE) && (grant_reg == GW'(gi));
        end
    endgenerate

    rr_picker #(
        .R(R)
    ) u_picker (
        .req    (req_eligible),
        .rr_ptr (rr_ptr_reg),
        .valid  (pick_valid),
        .index  (pick_index)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        alu_start  = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (pick_valid) begin
                    state_next = START;
                end
            end
            START: begin
                alu_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (alu_finished) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr_reg     <= '0;
            grant_reg      <= '0;
            just_acked_reg <= 1'b0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            res_y_reg      <= '0;
            res_x_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    just_acked_reg <= 1'b0;
                    if (pick_valid) begin
                        grant_reg <= pick_index;
                        alu_a_reg <= a_slot[pick_index];
                        alu_b_reg <= b_slot[pick_index];
                    end
                end
                WAIT: begin
                    if (alu_finished) begin
                        res_y_reg <= alu_Y;
                        res_x_reg <= alu_X;
                    end
                end
                DONE: begin
                    rr_ptr_reg     <= GW'(wrap_inc(int'(grant_reg), R));
                    just_acked_reg <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign grant = grant_reg;
    assign alu_A = alu_a_reg;
    assign alu_B = alu_b_reg;
    assign res_Y = res_y_reg;
    assign res_X = res_x_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: hand-derived vector table, corner
// sequences and randomized operations against a transaction-level model.
module tb_alu_arbiter;
    localparam int N = 4;
    localparam int R = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [R-1:0]         req;
    logic [R*N-1:0]       req_A, req_B;
    logic [R-1:0]         ack;
    logic [N-1:0]         res_Y, res_X, alu_A, alu_B, alu_Y, alu_X;
    logic [$clog2(R)-1:0] grant;
    logic                 busy, alu_start, alu_finished;

    int checks   = 0;
    int failures = 0;

    // Model state: next round-robin start position and the requester
    // excluded from the next IDLE evaluation (-1 when none).
    int rr_m   = 0;
    int mask_m = -1;

    typedef struct {
        logic [R-1:0] reqv;
        int           lat;
        bit           drop;
        bit           spur;
        int           exp;
    } vec_t;

    vec_t vecs[13];

    alu_arbiter #(.N(N), .R(R)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .req_A        (req_A),
        .req_B        (req_B),
        .ack          (ack),
        .res_Y        (res_Y),
        .res_X        (res_X),
        .grant        (grant),
        .busy         (busy),
        .alu_start    (alu_start),
        .alu_finished (alu_finished),
        .alu_A        (alu_A),
        .alu_B        (alu_B),
        .alu_Y        (alu_Y),
        .alu_X        (alu_X)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [R*N-1:0] rand_ops();
        return (R*N)'($urandom);
    endfunction

    function automatic int model_pick(input logic [R-1:0] reqv);
        for (int k = 0; k < R; k++) begin
            int i;
            i = (rr_m + k) % R;
            if (reqv[i] && i != mask_m) return i;
        end
        return -1;
    endfunction

    // At most one ack bit, and never together with alu_start.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            checks++;
            if ($countones(ack) > 1 || (ack != '0 && alu_start)) begin
                failures++;
                $display("FAIL ack_exclusive ack=%b alu_start=%b", ack, alu_start);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        req = '0;
        alu_finished = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_start", alu_start, 0);
        check("rst_grant", grant, 0);
        check("rst_alu_A", alu_A, 0);
        check("rst_alu_B", alu_B, 0);
        check("rst_res_Y", res_Y, 0);
        check("rst_res_X", res_X, 0);
        rr_m = 0;
        mask_m = -1;
        reset = 1'b1;
        $display("txn reset");
    endtask

    // Called at the negedge of an IDLE cycle; ALU answers 'lat' cycles after start.
    task automatic do_txn(input logic [R-1:0] reqv, input logic [R*N-1:0] ap,
                          input logic [R*N-1:0] bp, input int lat, input bit drop,
                          input bit spur, input int exp);
        logic [N-1:0] ea, eb, ey, ex;
        check("idle_busy", busy, 0);
        req = reqv;
        req_A = ap;
        req_B = bp;
        mask_m = -1;
        @(negedge clock);
        if (exp < 0) begin
            check("nogrant_start", alu_start, 0);
            check("nogrant_busy", busy, 0);
            $display("txn req=%b no grant", reqv);
            return;
        end
        ea = ap[exp*N +: N];
        eb = bp[exp*N +: N];
        ey = N'(ea + eb);
        ex = ea ^ eb;
        check("start", alu_start, 1);
        check("start_grant", grant, exp);
        check("start_alu_A", alu_A, ea);
        check("start_alu_B", alu_B, eb);
        check("start_ack", ack, 0);
        alu_finished = spur;
        req_A = rand_ops();
        req_B = rand_ops();
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            alu_finished = 1'b0;
            if (drop && k == 1) req = '0;
            check("wait_busy", busy, 1);
            check("wait_start", alu_start, 0);
            check("wait_ack", ack, 0);
            check("wait_alu_A", alu_A, ea);
            check("wait_alu_B", alu_B, eb);
            if (k == lat) begin
                alu_finished = 1'b1;
                alu_Y = ey;
                alu_X = ex;
            end else begin
                alu_Y = N'($urandom);
                alu_X = N'($urandom);
            end
        end
        @(negedge clock);
        alu_finished = 1'b0;
        alu_Y = N'($urandom);
        alu_X = N'($urandom);
        check("done_ack", ack, 32'(1) << exp);
        check("done_res_Y", res_Y, ey);
        check("done_res_X", res_X, ex);
        check("done_start", alu_start, 0);
        @(negedge clock);
        check("after_ack", ack, 0);
        check("after_busy", busy, 0);
        check("after_res_Y", res_Y, ey);
        rr_m = (exp + 1) % R;
        mask_m = exp;
        $display("txn req=%b winner=%0d lat=%0d drop=%0d spur=%0d Y=%0h X=%0h",
                 reqv, exp, lat, drop, spur, ey, ex);
    endtask

    initial begin
        reset = 1'b0;
        req = '0;
        req_A = '0;
        req_B = '0;
        alu_finished = 1'b0;
        alu_Y = '0;
        alu_X = '0;

        // Expected winners derived by hand from a fresh reset (rr_ptr 0).
        vecs[0]  = '{4'b1111, 3, 1'b0, 1'b0,  0};
        vecs[1]  = '{4'b1111, 3, 1'b0, 1'b0,  1};
        vecs[2]  = '{4'b1111, 3, 1'b0, 1'b0,  2};
        vecs[3]  = '{4'b1111, 3, 1'b0, 1'b0,  3};
        vecs[4]  = '{4'b1111, 3, 1'b0, 1'b0,  0};
        vecs[5]  = '{4'b0100, 2, 1'b1, 1'b0,  2};
        vecs[6]  = '{4'b1000, 3, 1'b0, 1'b0,  3};
        vecs[7]  = '{4'b1001, 3, 1'b0, 1'b0,  0};
        vecs[8]  = '{4'b0000, 3, 1'b0, 1'b0, -1};
        vecs[9]  = '{4'b0001, 1, 1'b0, 1'b1,  0};
        vecs[10] = '{4'b0001, 3, 1'b0, 1'b0, -1};
        vecs[11] = '{4'b0001, 3, 1'b0, 1'b0,  0};
        vecs[12] = '{4'b0010, 5, 1'b0, 1'b1,  1};

        do_reset();
        do_txn(4'b0001, 16'h0005, 16'h0003, 3, 1'b0, 1'b0, 0);
        do_reset();

        foreach (vecs[i]) begin
            do_txn(vecs[i].reqv, rand_ops(), rand_ops(), vecs[i].lat,
                   vecs[i].drop, vecs[i].spur, vecs[i].exp);
        end

        // Reset while waiting on the ALU, then a stray finish pulse in IDLE.
        req = 4'b0100;
        req_A = rand_ops();
        req_B = rand_ops();
        @(negedge clock);
        check("rw_start", alu_start, 1);
        check("rw_grant", grant, 2);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rw_busy", busy, 0);
        check("rw_ack", ack, 0);
        check("rw_start_low", alu_start, 0);
        check("rw_grant_zero", grant, 0);
        reset = 1'b1;
        req = '0;
        alu_finished = 1'b1;
        rr_m = 0;
        mask_m = -1;
        @(negedge clock);
        alu_finished = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("stray_ack", ack, 0);
            check("stray_busy", busy, 0);
            @(negedge clock);
        end
        $display("txn reset_in_wait");

        for (int it = 0; it < 40; it++) begin
            logic [R-1:0] rv;
            rv = R'($urandom_range(0, (1 << R) - 1));
            do_txn(rv, rand_ops(), rand_ops(), $urandom_range(1, 4),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), model_pick(rv));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
